aes_ctr_stream: RTL

Parametrised multi-block AES-CTR streaming engine. It generates successive counter blocks {nonce, counter}, issues them to an external fixed-latency block-cipher core, and buffers the returned keystream in a credit-limited FIFO. Each keystream block is XORed with a valid/ready data stream. CTR is symmetric, so a single datapath both encrypts and decrypts. The block sits between the cipher core (key is wired directly to the core, not through this block) and the bus-side data streams.

---
 rtl/aes_ctr_pkg.sv | 28 ++
 rtl/aes_ctr_ks_fifo.sv | 62 ++++++
 rtl/aes_ctr_stream.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-CTR streaming engine: default widths,
// controller state encoding and the counter-block formatter.
package aes_ctr_pkg;

   localparam int BLOCK_W_DEF = 128;
   localparam int CTR_W_DEF   = 64;
   localparam int LEN_W_DEF   = 16;
   // Widest block the formatter can build; callers slice down to their width.
   localparam int MAX_W       = 256;

   typedef enum logic [1:0] {
      ST_FLUSH,
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   // Counter block = {nonce, counter}; the counter occupies the low ctr_w bits.
   function automatic logic [MAX_W-1:0] ctr_block(input logic [MAX_W-1:0] nonce,
                                                  input logic [MAX_W-1:0] ctr,
                                                  input int               ctr_w);
      logic [MAX_W-1:0] mask;
      mask = '1;
      mask = ~(mask << ctr_w);
      return (nonce << ctr_w) | (ctr & mask);
   endfunction

endpackage

// File: rtl/aes_ctr_ks_fifo.sv
// Synchronous keystream FIFO with occupancy count. A push into an empty FIFO
// becomes visible at the head only on the following cycle (no bypass).
module aes_ctr_ks_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 64,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign rdata = mem_q[rd_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

   // Pointer and count next-state; pushes when full and pops when empty are dropped.
   always_comb begin
      do_push = push && (cnt_q != CW'(DEPTH));
      do_pop  = pop && (cnt_q != '0);
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/aes_ctr_stream.sv
// AES-CTR streaming engine: issues {nonce, counter} blocks to a fixed-latency
// cipher core under a credit limit, buffers the keystream and XORs it onto a
// valid/ready data stream. The same path encrypts and decrypts.
module aes_ctr_stream import aes_ctr_pkg::*; #(
   parameter int BLOCK_W      = BLOCK_W_DEF,
   parameter int CTR_W        = CTR_W_DEF,
   parameter int LEN_W        = LEN_W_DEF,
   parameter int CORE_LATENCY = 41,
   parameter int FIFO_DEPTH   = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [BLOCK_W-CTR_W-1:0] nonce,
   input  logic [CTR_W-1:0]         counter_init,
   input  logic [LEN_W-1:0]         num_blocks,
   output logic                     busy,
   output logic                     done,
   output logic                     ctr_wrap_err,
   output logic                     core_req_valid,
   output logic [BLOCK_W-1:0]       core_req_block,
   input  logic                     core_rsp_valid,
   input  logic [BLOCK_W-1:0]       core_rsp_block,
   input  logic                     din_valid,
   output logic                     din_ready,
   input  logic [BLOCK_W-1:0]       din_data,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [BLOCK_W-1:0]       dout_data,
   output logic                     dout_last
);

   localparam int NONCE_W = BLOCK_W - CTR_W;
   localparam int FCW     = $clog2(FIFO_DEPTH + 1);
   localparam int OCW     = FCW + 1;
   localparam int FLW     = $clog2(CORE_LATENCY + 1);

   state_e               state_q, state_d;
   logic [FLW-1:0]       flush_q, flush_d;
   logic [NONCE_W-1:0]   nonce_q, nonce_d;
   logic [CTR_W-1:0]     ctr_q, ctr_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     issued_q, issued_d;
   logic [LEN_W-1:0]     out_q, out_d;
   logic [FCW-1:0]       in_flight_q, in_flight_d;
   logic                 wrap_pend_q, wrap_pend_d;
   logic                 wrap_err_q, wrap_err_d;

   logic                 run, issue, push, xfer, fifo_ne;
   logic [OCW-1:0]       occ;
   logic [BLOCK_W-1:0]   fifo_head;
   logic [FCW-1:0]       fifo_count;
   logic                 fifo_empty;
   logic [MAX_W-1:0]     blk_wide;
   logic                 unused_blk_hi;

   // Credit: responses still in the core plus buffered keystream never exceed
   // the FIFO depth, so a returning response always has a free slot.
   assign run      = (state_q == ST_RUN);
   assign occ      = OCW'(in_flight_q) + OCW'(fifo_count);
   assign issue    = run && (issued_q < len_q) && (occ < OCW'(FIFO_DEPTH));
   assign push     = run && core_rsp_valid;
   assign fifo_ne  = !fifo_empty;

   assign blk_wide       = ctr_block(MAX_W'(nonce_q), MAX_W'(ctr_q), CTR_W);
   assign unused_blk_hi  = ^blk_wide[MAX_W-1:BLOCK_W];
   assign core_req_valid = issue;
   assign core_req_block = blk_wide[BLOCK_W-1:0];

   // Zero-latency stream join: data moves only when keystream is buffered.
   assign dout_valid   = run && din_valid && fifo_ne;
   assign din_ready    = run && dout_ready && fifo_ne;
   assign dout_data    = din_data ^ fifo_head;
   assign xfer         = din_valid && din_ready;
   assign dout_last    = run && (out_q == len_q - 1'b1);
   assign busy         = (state_q == ST_FLUSH) || run;
   assign done         = (state_q == ST_DONE);
   assign ctr_wrap_err = wrap_err_q;

   aes_ctr_ks_fifo #(
      .WIDTH (BLOCK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (core_rsp_block),
      .pop   (xfer),
      .rdata (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   // Controller next-state: flush, message launch, issue/credit and completion.
   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      nonce_d     = nonce_q;
      ctr_d       = ctr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      out_d       = out_q;
      in_flight_d = in_flight_q;
      wrap_pend_d = wrap_pend_q;
      wrap_err_d  = wrap_err_q;

      // An issue right after an all-ones counter means the counter wrapped.
      if (issue) begin
         ctr_d       = ctr_q + 1'b1;
         issued_d    = issued_q + 1'b1;
         wrap_pend_d = &ctr_q;
         if (wrap_pend_q) wrap_err_d = 1'b1;
      end

      case ({issue, push})
         2'b10:   in_flight_d = in_flight_q + 1'b1;
         2'b01:   in_flight_d = in_flight_q - 1'b1;
         default: in_flight_d = in_flight_q;
      endcase

      if (xfer) out_d = out_q + 1'b1;

      case (state_q)
         ST_FLUSH: begin
            // Ride out responses to requests made before reset.
            if (flush_q <= FLW'(1)) state_d = ST_IDLE;
            else                    flush_d = flush_q - 1'b1;
         end
         ST_IDLE: begin
            if (start) begin
               wrap_err_d  = 1'b0;
               wrap_pend_d = 1'b0;
               if (num_blocks != '0) begin
                  nonce_d  = nonce;
                  ctr_d    = counter_init;
                  len_d    = num_blocks;
                  issued_d = '0;
                  out_d    = '0;
                  state_d  = ST_RUN;
               end else begin
                  state_d  = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (xfer && (out_q == len_q - 1'b1)) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_FLUSH;
      endcase
   end

   // Controller registers; reset aborts any message and re-enters the flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FLUSH;
         flush_q     <= FLW'(CORE_LATENCY);
         nonce_q     <= '0;
         ctr_q       <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         out_q       <= '0;
         in_flight_q <= '0;
         wrap_pend_q <= 1'b0;
         wrap_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         nonce_q     <= nonce_d;
         ctr_q       <= ctr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         out_q       <= out_d;
         in_flight_q <= in_flight_d;
         wrap_pend_q <= wrap_pend_d;
         wrap_err_q  <= wrap_err_d;
      end
   end

endmodule
